controller_leds_pio_writer: RTL and testbench

- Avalon-MM master that drives a single-register output-PIO slave, such as the LED boost-select register.
- Accepts a DATA_W-bit value over a valid/ready command interface and issues one write to PIO offset 0.
- Periodically rewrites the last value (refresh) so that a PIO reset or glitch self-heals.
- Sits between controller LED logic and the PIO slave; honours waitrequest, although the PIO slave itself is zero-wait.

---
 rtl/controller_leds_pio_writer.sv | 165 ++++++++++++++++
 tb/tb_controller_leds_pio_writer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/controller_leds_pio_writer.sv
// Avalon-MM master that writes a shadowed value to a single-register output PIO and refreshes it periodically.
// Define CONTROLLER_LEDS_PIO_READBACK_EN to verify every write with a read and flag mismatches on err.
module controller_leds_pio_writer #(
   parameter int unsigned DATA_W         = 6,
   parameter int unsigned REFRESH_CYCLES = 1000000,
   parameter int unsigned CNT_W          = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              cmd_ready,
   output logic [1:0]        avm_address,
   output logic              avm_chipselect,
   output logic              avm_write_n,
   output logic              avm_read,
   output logic [31:0]       avm_writedata,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_waitrequest,
   output logic              busy,
   output logic              err,
   input  logic              err_clr,
   output logic [CNT_W-1:0]  write_count
);

   localparam int unsigned    REF_W      = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [REF_W-1:0] REF_RELOAD = (REFRESH_CYCLES == 0) ? '0 : REF_W'(REFRESH_CYCLES - 1);

`ifdef CONTROLLER_LEDS_PIO_READBACK_EN
   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_e;
`else
   typedef enum logic {ST_IDLE, ST_WRITE} state_e;
`endif

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   shadow_q, shadow_d;
   logic                shadow_valid_q, shadow_valid_d;
   logic                refresh_pending_q, refresh_pending_d;
   logic [REF_W-1:0]    refresh_cnt_q, refresh_cnt_d;
   logic [CNT_W-1:0]    write_count_q, write_count_d;
   logic                err_q, err_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                cs_q, cs_d;
   logic                write_n_q, write_n_d;
   logic                read_q, read_d;
   logic [31:0]         writedata_q, writedata_d;
   logic                busy_q, busy_d;

   // Inputs that only matter in some builds (or only in part) are folded here.
   logic unused_inputs;
   assign unused_inputs = ^{err_clr, avm_readdata};

   // Next-state and registered-output logic.
   always_comb begin
      state_d           = state_q;
      shadow_d          = shadow_q;
      shadow_valid_d    = shadow_valid_q;
      refresh_pending_d = refresh_pending_q;
      refresh_cnt_d     = refresh_cnt_q;
      write_count_d     = write_count_q;
      err_d             = err_q;

      if (REFRESH_CYCLES != 0) begin
         if (refresh_cnt_q == '0) begin
            refresh_cnt_d     = REF_RELOAD;
            refresh_pending_d = 1'b1;
         end else begin
            refresh_cnt_d = refresh_cnt_q - REF_W'(1);
         end
      end

`ifdef CONTROLLER_LEDS_PIO_READBACK_EN
      if (err_clr) err_d = 1'b0;
`endif

      // Servicing or superseding a refresh clears pending even if the timer expires on the same edge.
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               shadow_d          = cmd_data;
               shadow_valid_d    = 1'b1;
               refresh_pending_d = 1'b0;
               state_d           = ST_WRITE;
            end else if (refresh_pending_q && shadow_valid_q) begin
               refresh_pending_d = 1'b0;
               state_d           = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (!avm_waitrequest) begin
               write_count_d = write_count_q + CNT_W'(1);
`ifdef CONTROLLER_LEDS_PIO_READBACK_EN
               state_d       = ST_READ;
`else
               state_d       = ST_IDLE;
`endif
            end
         end
`ifdef CONTROLLER_LEDS_PIO_READBACK_EN
         ST_READ: begin
            if (!avm_waitrequest) begin
               if (avm_readdata[DATA_W-1:0] != shadow_q) err_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      // Bus outputs follow the upcoming state so they are valid the cycle after the deciding edge.
      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      cs_d        = (state_d != ST_IDLE);
      write_n_d   = (state_d != ST_WRITE);
`ifdef CONTROLLER_LEDS_PIO_READBACK_EN
      read_d      = (state_d == ST_READ);
`else
      read_d      = 1'b0;
`endif
      writedata_d = (state_d == ST_WRITE) ? 32'(shadow_d) : 32'h0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q           <= ST_IDLE;
         shadow_q          <= '0;
         shadow_valid_q    <= 1'b0;
         refresh_pending_q <= 1'b0;
         refresh_cnt_q     <= REF_RELOAD;
         write_count_q     <= '0;
         err_q             <= 1'b0;
         cmd_ready_q       <= 1'b1;
         cs_q              <= 1'b0;
         write_n_q         <= 1'b1;
         read_q            <= 1'b0;
         writedata_q       <= 32'h0;
         busy_q            <= 1'b0;
      end else begin
         state_q           <= state_d;
         shadow_q          <= shadow_d;
         shadow_valid_q    <= shadow_valid_d;
         refresh_pending_q <= refresh_pending_d;
         refresh_cnt_q     <= refresh_cnt_d;
         write_count_q     <= write_count_d;
         err_q             <= err_d;
         cmd_ready_q       <= cmd_ready_d;
         cs_q              <= cs_d;
         write_n_q         <= write_n_d;
         read_q            <= read_d;
         writedata_q       <= writedata_d;
         busy_q            <= busy_d;
      end
   end

   assign cmd_ready      = cmd_ready_q;
   assign avm_address    = 2'b00;
   assign avm_chipselect = cs_q;
   assign avm_write_n    = write_n_q;
   assign avm_read       = read_q;
   assign avm_writedata  = writedata_q;
   assign busy           = busy_q;
   assign err            = err_q;
   assign write_count    = write_count_q;

endmodule

// File: tb/tb_controller_leds_pio_writer.sv
// Self-checking bench for controller_leds_pio_writer: one instance without refresh for bus timing,
// one with an 8-cycle refresh and a 3-bit write counter for refresh and wrap behaviour.
module tb_controller_leds_pio_writer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance (refresh disabled).
   logic        rst_n, valid, wr, errclr;
   logic [5:0]  data;
   logic [31:0] rdata;
   logic        rdy, cs, wn, rd, bsy, er;
   logic [1:0]  addr;
   logic [31:0] wd;
   logic [15:0] cnt;

   // Refresh instance.
   logic        r_rst_n, r_valid, r_wr, r_errclr;
   logic [5:0]  r_data;
   logic [31:0] r_rdata;
   logic        r_rdy, r_cs, r_wn, r_rd, r_bsy, r_er;
   logic [1:0]  r_addr;
   logic [31:0] r_wd;
   logic [2:0]  r_cnt;

   controller_leds_pio_writer #(.DATA_W(6), .REFRESH_CYCLES(0), .CNT_W(16)) dut (
      .clk(clk), .reset_n(rst_n), .cmd_valid(valid), .cmd_data(data), .cmd_ready(rdy),
      .avm_address(addr), .avm_chipselect(cs), .avm_write_n(wn), .avm_read(rd),
      .avm_writedata(wd), .avm_readdata(rdata), .avm_waitrequest(wr),
      .busy(bsy), .err(er), .err_clr(errclr), .write_count(cnt));

   controller_leds_pio_writer #(.DATA_W(6), .REFRESH_CYCLES(8), .CNT_W(3)) dut_r (
      .clk(clk), .reset_n(r_rst_n), .cmd_valid(r_valid), .cmd_data(r_data), .cmd_ready(r_rdy),
      .avm_address(r_addr), .avm_chipselect(r_cs), .avm_write_n(r_wn), .avm_read(r_rd),
      .avm_writedata(r_wd), .avm_readdata(r_rdata), .avm_waitrequest(r_wr),
      .busy(r_bsy), .err(r_er), .err_clr(r_errclr), .write_count(r_cnt));

   int passed = 0;
   int total  = 0;

   // Write monitor for the refresh instance: negedge index and data of every write cycle.
   int          r_neg = 0;
   int          r_wcyc[$];
   logic [31:0] r_wdat[$];
   always @(negedge clk) begin
      r_neg = r_neg + 1;
      if (r_cs && !r_wn) begin
         r_wcyc.push_back(r_neg);
         r_wdat.push_back(r_wd);
      end
   end

   typedef struct {
      logic        v;
      logic [5:0]  d;
      logic        w;
      logic        cs;
      logic        wn;
      logic [31:0] wd;
      logic        rdy;
      logic        bsy;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total = total + 1;
      if (got === exp) passed = passed + 1;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   function automatic logic [63:0] pk(input logic c, input logic n, input logic r, input logic [31:0] d,
                                      input logic y, input logic b, input logic e, input logic [15:0] k);
      return 64'({c, n, r, d, y, b, e, k});
   endfunction

   function automatic logic [63:0] main_out();
      return pk(cs, wn, rd, wd, rdy, bsy, er, cnt);
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      int m, n_win, win_cyc, budget;
      logic [31:0] win_dat;
      logic ok_r;

      rst_n = 1'b0; valid = 1'b0; data = '0; wr = 1'b0; errclr = 1'b0; rdata = '0;
      r_rst_n = 1'b0; r_valid = 1'b0; r_data = '0; r_wr = 1'b0; r_errclr = 1'b0; r_rdata = '0;
      ok_r = 1'b1;

      vecs[0]  = '{1'b1, 6'h2A, 1'b0, 1'b1, 1'b0, 32'h2A, 1'b0, 1'b1, 16'd0};
      vecs[1]  = '{1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 1'b0, 16'd1};
      vecs[2]  = '{1'b1, 6'h15, 1'b1, 1'b1, 1'b0, 32'h15, 1'b0, 1'b1, 16'd1};
      vecs[3]  = '{1'b0, 6'h00, 1'b1, 1'b1, 1'b0, 32'h15, 1'b0, 1'b1, 16'd1};
      vecs[4]  = '{1'b0, 6'h00, 1'b1, 1'b1, 1'b0, 32'h15, 1'b0, 1'b1, 16'd1};
      vecs[5]  = '{1'b0, 6'h00, 1'b1, 1'b1, 1'b0, 32'h15, 1'b0, 1'b1, 16'd1};
      vecs[6]  = '{1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 1'b0, 16'd2};
      vecs[7]  = '{1'b1, 6'h3F, 1'b0, 1'b1, 1'b0, 32'h3F, 1'b0, 1'b1, 16'd2};
      vecs[8]  = '{1'b1, 6'h01, 1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 1'b0, 16'd3};
      vecs[9]  = '{1'b1, 6'h01, 1'b0, 1'b1, 1'b0, 32'h01, 1'b0, 1'b1, 16'd3};
      vecs[10] = '{1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 1'b0, 16'd4};
      vecs[11] = '{1'b0, 6'h00, 1'b1, 1'b0, 1'b1, 32'h00, 1'b1, 1'b0, 16'd4};

      #12;
      rst_n = 1'b1; r_rst_n = 1'b1;
      #1;
      check("reset_state", main_out(), pk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'd0));

`ifndef CONTROLLER_LEDS_PIO_READBACK_EN
      for (int i = 0; i < 12; i++) begin
         valid = vecs[i].v; data = vecs[i].d; wr = vecs[i].w;
         tick();
         check($sformatf("vec%0d", i), main_out(),
               pk(vecs[i].cs, vecs[i].wn, 1'b0, vecs[i].wd, vecs[i].rdy, vecs[i].bsy, 1'b0, vecs[i].cnt));
      end
      valid = 1'b0; wr = 1'b0;
`else
      // Matching readback: upper readdata bits ignored.
      rdata = 32'hFFFFFF05; valid = 1'b1; data = 6'h05;
      tick();
      valid = 1'b0;
      check("rb_write", main_out(), pk(1'b1, 1'b0, 1'b0, 32'h05, 1'b0, 1'b1, 1'b0, 16'd0));
      tick();
      check("rb_read", main_out(), pk(1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 16'd1));
      tick();
      check("rb_ok", main_out(), pk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'd1));
      // Mismatching readback sets sticky err until err_clr.
      rdata = 32'h00000004; valid = 1'b1; data = 6'h05;
      tick();
      valid = 1'b0;
      tick();
      tick();
      check("rb_err_set", 64'(er), 64'(1));
      tick();
      tick();
      check("rb_err_hold", 64'(er), 64'(1));
      errclr = 1'b1;
      tick();
      errclr = 1'b0;
      check("rb_err_clr", 64'(er), 64'(0));
      tick();
      check("rb_err_stays_clr", main_out(), pk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'd2));
`endif

      // No refresh writes before any command.
      for (int i = 0; i < 20; i++) tick();
      check("r_no_writes", 64'(r_wcyc.size()), 64'(0));
      check("r_count_zero", 64'(r_cnt), 64'(0));

      r_valid = 1'b1; r_data = 6'h07;
      tick();
      r_valid = 1'b0;
      budget = 0;
      while (r_wcyc.size() < 5 && budget < 80) begin
         tick();
         budget++;
      end
      if (r_wcyc.size() < 5) begin
         check("r_refresh_timeout", 64'(r_wcyc.size()), 64'(5));
         ok_r = 1'b0;
      end

      if (ok_r) begin
         check("r_cmd_data", 64'(r_wdat[0]), 64'h7);
         for (int i = 2; i < 5; i++) begin
            check($sformatf("r_gap%0d", i), 64'(r_wcyc[i] - r_wcyc[i-1]), 64'(8));
            check($sformatf("r_data%0d", i), 64'(r_wdat[i]), 64'h7);
         end

         // Command lands on the refresh-expiry edge: exactly one write, no extra refresh.
         m = r_wcyc[4];
         for (int i = 0; i < 6; i++) tick();
         r_valid = 1'b1; r_data = 6'h3F;
         tick();
         r_valid = 1'b0;
         for (int i = 0; i < 8; i++) tick();
         n_win = 0; win_cyc = 0; win_dat = '0;
         for (int i = 0; i < r_wcyc.size(); i++) begin
            if (r_wcyc[i] > m && r_wcyc[i] <= m + 15) begin
               n_win++;
               win_cyc = r_wcyc[i];
               win_dat = r_wdat[i];
            end
         end
         check("coinc_count", 64'(n_win), 64'(1));
         check("coinc_time", 64'(win_cyc - m), 64'(7));
         check("coinc_data", 64'(win_dat), 64'h3F);
         tick();
         check("post_refresh_time", 64'(r_wcyc[r_wcyc.size()-1] - m), 64'(16));
         check("post_refresh_data", 64'(r_wdat[r_wdat.size()-1]), 64'h3F);

         // write_count wraps modulo 8.
         budget = 0;
         while (r_wcyc.size() < 9 && budget < 40) begin
            tick();
            budget++;
         end
         tick();
         check("r_count_wrap", 64'(r_cnt), 64'(r_wcyc.size() % 8));
      end

      // Asynchronous reset while a write is stalled.
      valid = 1'b1; data = 6'h15; wr = 1'b1;
      tick();
      valid = 1'b0;
      check("stall_write_active", 64'({cs, wn}), 64'({1'b1, 1'b0}));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", main_out(), pk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'd0));
      rst_n = 1'b1;
      wr = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
